// File: rtl/id_stage.sv
// RV32I decode stage: decodes the fetched instruction, reads/forwards rs1/rs2,
// stalls on load-use, and registers the decode bundle for EX.
module id_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [XLEN-1:0]   if_pc,
  input  logic [31:0]       if_inst,
  output logic              re1,
  output logic [REG_AW-1:0] raddr1,
  input  logic [XLEN-1:0]   rdata1,
  output logic              re2,
  output logic [REG_AW-1:0] raddr2,
  input  logic [XLEN-1:0]   rdata2,
  input  logic              ex_wreg,
  input  logic [REG_AW-1:0] ex_waddr,
  input  logic [XLEN-1:0]   ex_wdata,
  input  logic              ex_is_load,
  input  logic              flush,
  output logic              id_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   id_pc,
  output logic [6:0]        id_opcode,
  output logic [2:0]        id_funct3,
  output logic [3:0]        id_alu_op,
  output logic [XLEN-1:0]   id_op1,
  output logic [XLEN-1:0]   id_op2,
  output logic [XLEN-1:0]   id_imm,
  output logic              id_use_imm,
  output logic [REG_AW-1:0] id_waddr,
  output logic              id_wreg,
  output logic              id_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [6:0]        w_opc;
  logic [2:0]        w_f3;
  logic [REG_AW-1:0] w_rd;
  logic [XLEN-1:0]   w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic              w_use1, w_use2, w_wr, w_uimm, w_ill;
  logic [XLEN-1:0]   w_imm;
  logic [3:0]        w_alu;
  logic              w_wreg;
  logic              w_fwd1, w_fwd2, w_haz1, w_haz2, w_hazard, w_adv;
  logic [XLEN-1:0]   w_op1, w_op2;

  logic              r_valid;
  logic [XLEN-1:0]   r_pc, r_op1, r_op2, r_imm;
  logic [6:0]        r_opcode;
  logic [2:0]        r_funct3;
  logic [3:0]        r_alu_op;
  logic              r_use_imm, r_wreg, r_illegal;
  logic [REG_AW-1:0] r_waddr;

  assign w_opc = if_inst[6:0];
  assign w_f3  = if_inst[14:12];
  assign w_rd  = if_inst[11:7];

  assign w_imm_i = {{(XLEN-12){if_inst[31]}}, if_inst[31:20]};
  assign w_imm_s = {{(XLEN-12){if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
  assign w_imm_b = {{(XLEN-13){if_inst[31]}}, if_inst[31], if_inst[7],
                    if_inst[30:25], if_inst[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-32){if_inst[31]}}, if_inst[31:12], 12'h000};
  assign w_imm_j = {{(XLEN-21){if_inst[31]}}, if_inst[31], if_inst[19:12],
                    if_inst[20], if_inst[30:21], 1'b0};

  // Illegal opcodes decode to an inert bundle: no reads, no write, no imm.
  always_comb begin
    w_use1 = 1'b0;
    w_use2 = 1'b0;
    w_wr   = 1'b0;
    w_uimm = 1'b1;
    w_ill  = 1'b0;
    w_imm  = '0;
    w_alu  = 4'b0000;
    case (w_opc)
      OPC_LUI, OPC_AUIPC: begin w_wr = 1'b1; w_imm = w_imm_u; end
      OPC_JAL:            begin w_wr = 1'b1; w_imm = w_imm_j; end
      OPC_JALR, OPC_LOAD: begin w_use1 = 1'b1; w_wr = 1'b1; w_imm = w_imm_i; end
      OPC_OPIMM: begin
        w_use1 = 1'b1;
        w_wr   = 1'b1;
        w_imm  = w_imm_i;
        w_alu  = {if_inst[30] & (w_f3 == 3'b101), w_f3};
      end
      OPC_BRANCH: begin w_use1 = 1'b1; w_use2 = 1'b1; w_uimm = 1'b0; w_imm = w_imm_b; end
      OPC_STORE:  begin w_use1 = 1'b1; w_use2 = 1'b1; w_imm = w_imm_s; end
      OPC_OP: begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        w_wr   = 1'b1;
        w_uimm = 1'b0;
        w_alu  = {if_inst[30], w_f3};
      end
      default: begin w_ill = 1'b1; w_uimm = 1'b0; end
    endcase
  end

  assign w_wreg = w_wr & (w_rd != '0);

  assign re1    = w_use1 & if_valid;
  assign re2    = w_use2 & if_valid;
  assign raddr1 = if_inst[19:15];
  assign raddr2 = if_inst[24:20];

  // ALU results forward from EX; load results do not exist yet and stall instead.
  assign w_fwd1 = re1 & (raddr1 != '0) & ex_wreg & !ex_is_load & (ex_waddr == raddr1);
  assign w_fwd2 = re2 & (raddr2 != '0) & ex_wreg & !ex_is_load & (ex_waddr == raddr2);
  assign w_haz1 = re1 & (raddr1 != '0) & ex_wreg & ex_is_load & (ex_waddr == raddr1);
  assign w_haz2 = re2 & (raddr2 != '0) & ex_wreg & ex_is_load & (ex_waddr == raddr2);
  assign w_hazard = w_haz1 | w_haz2;

  assign w_op1 = (raddr1 == '0) ? '0 : (w_fwd1 ? ex_wdata : rdata1);
  assign w_op2 = (raddr2 == '0) ? '0 : (w_fwd2 ? ex_wdata : rdata2);

  assign w_adv    = !r_valid | ex_ready;
  assign if_ready = w_adv & !w_hazard & !flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_opcode  <= '0;
      r_funct3  <= '0;
      r_alu_op  <= '0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_imm     <= '0;
      r_use_imm <= 1'b0;
      r_waddr   <= '0;
      r_wreg    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_adv) begin
      // A hazard still captures, but as a bubble; fetch keeps the instruction.
      r_valid   <= if_valid & !w_hazard;
      r_pc      <= if_pc;
      r_opcode  <= w_opc;
      r_funct3  <= w_f3;
      r_alu_op  <= w_alu;
      r_op1     <= w_op1;
      r_op2     <= w_op2;
      r_imm     <= w_imm;
      r_use_imm <= w_uimm;
      r_waddr   <= w_rd;
      r_wreg    <= w_wreg;
      r_illegal <= w_ill;
    end
  end

  assign id_valid   = r_valid;
  assign id_pc      = r_pc;
  assign id_opcode  = r_opcode;
  assign id_funct3  = r_funct3;
  assign id_alu_op  = r_alu_op;
  assign id_op1     = r_op1;
  assign id_op2     = r_op2;
  assign id_imm     = r_imm;
  assign id_use_imm = r_use_imm;
  assign id_waddr   = r_waddr;
  assign id_wreg    = r_wreg;
  assign id_illegal = r_illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed vector table, corner sequences, then random
// traffic checked against a behavioural decode model.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_inst;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        ex_wreg;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        ex_is_load, flush, id_valid, ex_ready;
  logic [31:0] id_pc, id_op1, id_op2, id_imm;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [3:0]  id_alu_op;
  logic        id_use_imm, id_wreg, id_illegal;
  logic [4:0]  id_waddr;

  id_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_inst(if_inst),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .ex_wreg(ex_wreg), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .ex_is_load(ex_is_load), .flush(flush),
    .id_valid(id_valid), .ex_ready(ex_ready),
    .id_pc(id_pc), .id_opcode(id_opcode), .id_funct3(id_funct3),
    .id_alu_op(id_alu_op), .id_op1(id_op1), .id_op2(id_op2), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_waddr(id_waddr), .id_wreg(id_wreg),
    .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic        uimm, wreg, ill, u1, u2;
    logic [4:0]  rd, a1, a2;
  } dec_t;

  typedef struct {
    logic [31:0] inst;
    logic        vld, flsh, exw;
    logic [4:0]  exa;
    logic [31:0] exd;
    logic        exl;
    logic [31:0] rd1, rd2;
    logic        exr;
    logic        e_rdy, e_vld, e_chk;
    logic [31:0] e_op1, e_op2, e_imm;
    logic [3:0]  e_alu;
    logic        e_wreg, e_ill, e_uimm;
  } vec_t;

  vec_t vecs[$];

  // reference state
  logic         m_valid;
  logic         m_known;
  logic [149:0] m_b;
  logic [31:0]  pc_cnt = 32'h1000;

  task automatic chk(input string nm, input logic [149:0] got, input logic [149:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  function automatic dec_t mdec(input logic [31:0] in);
    dec_t d;
    logic signed [11:0] ti, ts;
    logic signed [12:0] tb;
    logic signed [20:0] tj;
    logic writes;
    ti = in[31:20];
    ts = {in[31:25], in[11:7]};
    tb = {in[31], in[7], in[30:25], in[11:8], 1'b0};
    tj = {in[31], in[19:12], in[20], in[30:21], 1'b0};
    d.opc = in[6:0]; d.f3 = in[14:12]; d.rd = in[11:7];
    d.a1 = in[19:15]; d.a2 = in[24:20];
    d.alu = 4'd0; d.imm = 32'd0; d.uimm = 1'b1; d.ill = 1'b0;
    d.u1 = 1'b0; d.u2 = 1'b0; writes = 1'b0;
    case (d.opc)
      7'b0110111, 7'b0010111: begin writes = 1; d.imm = in & 32'hFFFFF000; end
      7'b1101111: begin writes = 1; d.imm = 32'(tj); end
      7'b1100111, 7'b0000011: begin writes = 1; d.u1 = 1; d.imm = 32'(ti); end
      7'b0010011: begin
        writes = 1; d.u1 = 1; d.imm = 32'(ti);
        d.alu = {(d.f3 == 3'd5) ? in[30] : 1'b0, d.f3};
      end
      7'b1100011: begin d.u1 = 1; d.u2 = 1; d.uimm = 0; d.imm = 32'(tb); end
      7'b0100011: begin d.u1 = 1; d.u2 = 1; d.imm = 32'(ts); end
      7'b0110011: begin writes = 1; d.u1 = 1; d.u2 = 1; d.uimm = 0; d.alu = {in[30], d.f3}; end
      default: begin d.ill = 1; d.uimm = 0; end
    endcase
    d.wreg = writes && (d.rd != 0);
    return d;
  endfunction

  function automatic logic [31:0] mop(input logic [4:0] a, input logic re,
                                      input logic [31:0] rd);
    if (a == 0) return 32'd0;
    if (re && ex_wreg && !ex_is_load && ex_waddr == a) return ex_wdata;
    return rd;
  endfunction

  // Apply one cycle of inputs, check the combinational side, clock, check the bundle.
  task automatic step(input logic [31:0] inst, input logic vld, input logic flsh,
                      input logic exw, input logic [4:0] exa, input logic [31:0] exd,
                      input logic exl, input logic [31:0] rd1, input logic [31:0] rd2,
                      input logic exr, input logic rs, output logic rdy_seen);
    dec_t d;
    logic e_re1, e_re2, haz, adv, e_rdy;
    logic [149:0] nb;
    rst = rs; if_valid = vld; flush = flsh; if_inst = inst; if_pc = pc_cnt;
    ex_wreg = exw; ex_waddr = exa; ex_wdata = exd; ex_is_load = exl;
    rdata1 = rd1; rdata2 = rd2; ex_ready = exr;
    pc_cnt += 4;
    #1;
    d = mdec(inst);
    e_re1 = d.u1 && vld;
    e_re2 = d.u2 && vld;
    haz = exl && exw && ((e_re1 && d.a1 != 0 && exa == d.a1) ||
                         (e_re2 && d.a2 != 0 && exa == d.a2));
    adv = !m_valid || exr;
    e_rdy = adv && !haz && !flsh;
    rdy_seen = if_ready;
    if (rs) chk("comb", {137'd0, if_ready, re1, re2, raddr1, raddr2},
                {137'd0, e_rdy, e_re1, e_re2, d.a1, d.a2});
    nb = {if_pc, d.opc, d.f3, d.alu, mop(d.a1, e_re1, rd1), mop(d.a2, e_re2, rd2),
          d.imm, d.uimm, d.rd, d.wreg, d.ill};
    @(posedge clk);
    #1;
    if (!rs) begin
      m_valid = 0; m_b = '0; m_known = 1;
    end else if (flsh) begin
      m_valid = 0; m_known = 0;
    end else if (adv) begin
      m_valid = vld && !haz; m_b = nb; m_known = 1;
    end
    chk("valid", {149'd0, id_valid}, {149'd0, m_valid});
    if (m_known)
      chk("bundle", {id_pc, id_opcode, id_funct3, id_alu_op, id_op1, id_op2, id_imm,
                     id_use_imm, id_waddr, id_wreg, id_illegal}, m_b);
  endtask

  task automatic tv(input logic [31:0] inst, input logic vld, input logic flsh,
                    input logic exw, input logic [4:0] exa, input logic [31:0] exd,
                    input logic exl, input logic [31:0] rd1, input logic [31:0] rd2,
                    input logic e_rdy, input logic e_vld, input logic e_chk,
                    input logic [31:0] e_op1, input logic [31:0] e_op2,
                    input logic [31:0] e_imm, input logic [3:0] e_alu,
                    input logic e_wreg, input logic e_ill, input logic e_uimm);
    vec_t v;
    v.inst = inst; v.vld = vld; v.flsh = flsh; v.exw = exw; v.exa = exa;
    v.exd = exd; v.exl = exl; v.rd1 = rd1; v.rd2 = rd2; v.exr = 1'b1;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_chk = e_chk; v.e_op1 = e_op1;
    v.e_op2 = e_op2; v.e_imm = e_imm; v.e_alu = e_alu; v.e_wreg = e_wreg;
    v.e_ill = e_ill; v.e_uimm = e_uimm;
    vecs.push_back(v);
  endtask

  initial begin
    logic r;
    logic [31:0] ins;
    logic [6:0] opcs [10];
    opcs = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
             7'b0010011, 7'b1100011, 7'b0100011, 7'b0110011, 7'b0001111};
    m_valid = 0; m_known = 0; m_b = '0;

    //    inst          vld fl exw exa  exd       exl rd1     rd2    rdy ov chk op1       op2    imm          alu   wr il ui
    tv(32'h00500093, 1, 0, 0, 5'd0, 32'h0,    0, 32'h55,  32'h0,  1, 1, 1, 32'h0,    32'h0, 32'h5,        4'h0, 1, 0, 1);
    tv(32'h002081B3, 1, 0, 1, 5'd1, 32'h1234, 0, 32'h9,   32'h7,  1, 1, 1, 32'h1234, 32'h7, 32'h0,        4'h0, 1, 0, 0);
    tv(32'h002081B3, 1, 0, 1, 5'd2, 32'h1234, 1, 32'h9,   32'h7,  0, 0, 1, 32'h9,    32'h7, 32'h0,        4'h0, 1, 0, 0);
    tv(32'h002081B3, 1, 0, 0, 5'd2, 32'h1234, 0, 32'h9,   32'h7,  1, 1, 1, 32'h9,    32'h7, 32'h0,        4'h0, 1, 0, 0);
    tv(32'h407302B3, 1, 0, 1, 5'd7, 32'hAA,   0, 32'h10,  32'h3,  1, 1, 1, 32'h10,   32'hAA, 32'h0,       4'h8, 1, 0, 0);
    tv(32'h40315093, 1, 0, 0, 5'd0, 32'h0,    0, 32'h20,  32'h0,  1, 1, 1, 32'h20,   32'h0, 32'h403,      4'hD, 1, 0, 1);
    tv(32'h12345037, 1, 0, 0, 5'd0, 32'h0,    0, 32'h77,  32'h0,  1, 1, 1, 32'h77,   32'h0, 32'h12345000, 4'h0, 0, 0, 1);
    tv(32'hFE208EE3, 1, 1, 0, 5'd0, 32'h0,    0, 32'h1,   32'h2,  0, 0, 0, 32'h0,    32'h0, 32'h0,        4'h0, 0, 0, 0);
    tv(32'hFE208EE3, 1, 0, 0, 5'd0, 32'h0,    0, 32'h1,   32'h2,  1, 1, 1, 32'h1,    32'h2, 32'hFFFFFFFC, 4'h0, 0, 0, 0);
    tv(32'h0000000F, 1, 0, 0, 5'd0, 32'h0,    0, 32'h0,   32'h0,  1, 1, 1, 32'h0,    32'h0, 32'h0,        4'h0, 0, 1, 0);
    tv(32'hFE20AC23, 1, 0, 0, 5'd0, 32'h0,    0, 32'h100, 32'h5,  1, 1, 1, 32'h100,  32'h5, 32'hFFFFFFF8, 4'h0, 0, 0, 1);
    tv(32'h001000EF, 1, 0, 0, 5'd0, 32'h0,    0, 32'h0,   32'h33, 1, 1, 1, 32'h0,    32'h33, 32'h800,     4'h0, 1, 0, 1);
    tv(32'h00500093, 0, 0, 0, 5'd0, 32'h0,    0, 32'h0,   32'h0,  1, 0, 0, 32'h0,    32'h0, 32'h0,        4'h0, 0, 0, 0);

    // reset for two cycles with fetch presenting work
    step(32'h00500093, 1, 0, 0, 0, 0, 0, 1, 2, 1, 0, r);
    step(32'h00500093, 1, 0, 0, 0, 0, 0, 1, 2, 1, 0, r);
    chk("rst_zero", {id_valid, id_pc, id_opcode, id_funct3, id_alu_op, id_op1, id_op2,
                     id_imm, id_use_imm, id_waddr, id_wreg, id_illegal}, 150'd0);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      step(v.inst, v.vld, v.flsh, v.exw, v.exa, v.exd, v.exl, v.rd1, v.rd2, v.exr, 1, r);
      chk($sformatf("tv%0d_rdy", i), {149'd0, r}, {149'd0, v.e_rdy});
      chk($sformatf("tv%0d_vld", i), {149'd0, id_valid}, {149'd0, v.e_vld});
      if (v.e_chk)
        chk($sformatf("tv%0d_fields", i),
            {id_op1, id_op2, id_imm, id_alu_op, id_wreg, id_illegal, id_use_imm},
            {v.e_op1, v.e_op2, v.e_imm, v.e_alu, v.e_wreg, v.e_ill, v.e_uimm});
    end

    // backpressure: bundle held while EX stalls, fetch refused
    step(32'h00500093, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, r);
    for (int k = 0; k < 3; k++) begin
      step(32'h407302B3 + 32'(k << 7), 1, 0, 0, 0, 0, 0, 32'h11, 32'h22, 0, 1, r);
      chk("bp_rdy", {149'd0, r}, 150'd0);
      chk("bp_hold", {id_valid, id_imm, id_waddr}, {1'b1, 32'd5, 5'd1});
    end
    // flush and load-use hazard together: flush wins
    step(32'h002081B3, 1, 1, 1, 5'd1, 32'h9, 1, 0, 0, 1, 1, r);
    chk("flush_haz_rdy", {149'd0, r}, 150'd0);
    chk("flush_haz_vld", {149'd0, id_valid}, 150'd0);
    // load-use on rs2 of a store
    step(32'hFE20AC23, 1, 0, 1, 5'd2, 32'h9, 1, 0, 0, 1, 1, r);
    chk("st_haz_rdy", {149'd0, r}, 150'd0);
    // reset in the middle of a stall
    step(32'h00500093, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, r);
    step(32'h00A00113, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, r);
    step(32'h00A00113, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, r);
    chk("rst_stall", {149'd0, id_valid}, 150'd0);
    step(32'h00A00113, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, r);
    chk("rst_accept", {149'd0, r}, {149'd0, 1'b1});

    // random traffic; small register range to exercise forwarding and hazards
    for (int k = 0; k < 400; k++) begin
      ins = $urandom;
      ins[6:0] = opcs[$urandom_range(0, 9)];
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      ins[11:7]  = 5'($urandom_range(0, 3));
      step(ins, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
           1'($urandom), 5'($urandom_range(0, 3)), $urandom, 1'($urandom),
           $urandom, $urandom, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 49) != 0), r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
